// File: rtl/brd_ctrl.sv
// Baud-rate divisor update controller: shadows IBRD/FBRD writes and swaps them into the
// baud generator only between frames. Optional forced update: define BRD_CTRL_TIMEOUT_EN.
module brd_ctrl #(
    parameter logic [23:0] IBRD_RST       = 24'd26,
    parameter logic [7:0]  FBRD_RST       = 8'd0,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        tx_busy,
    input  logic        rx_busy,
    output logic [23:0] ibrd,
    output logic [7:0]  fbrd,
    output logic        brd_enable,
    output logic        brd_reset_n,
    output logic        update_done,
    output logic        cfg_err,
    output logic        timeout
);

    typedef enum logic [2:0] {S_IDLE, S_PENDING, S_QUIESCE, S_LOAD, S_RESTART} state_t;

    state_t      r_state, w_next;
    logic [23:0] r_ibrd_sh, r_ibrd;
    logic [7:0]  r_fbrd_sh, r_fbrd;
    logic        r_enable, r_brd_enable, r_brd_rst_n, r_cfg_err, r_load_cnt;
    logic        w_wr_acc, w_ctrl_wr, w_commit, w_bad_commit, w_busy, w_to_hit;

    assign w_wr_acc     = wr_valid && wr_ready;
    assign w_ctrl_wr    = w_wr_acc && (wr_addr == 2'd2);
    assign w_commit     = w_ctrl_wr && wr_data[1];
    assign w_bad_commit = w_commit && (r_ibrd_sh == 24'd0);
    assign w_busy       = tx_busy || rx_busy;

`ifdef BRD_CTRL_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (r_state == S_IDLE && w_next == S_PENDING)
            r_to_cnt <= '0;
        else if (r_state == S_PENDING)
            r_to_cnt <= r_to_cnt + 32'd1;
    end

    assign w_to_hit = (r_state == S_PENDING) && w_busy && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    logic w_unused;
    assign w_unused = ^wr_data[31:24];
`else
    assign w_to_hit = 1'b0;
    logic w_unused;
    assign w_unused = ^{wr_data[31:24], 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_commit && !w_bad_commit) w_next = S_PENDING;
            S_PENDING: if (!w_busy || w_to_hit)       w_next = S_QUIESCE;
            S_QUIESCE: w_next = S_LOAD;
            S_LOAD:    if (r_load_cnt)                w_next = S_RESTART;
            S_RESTART: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready    = (r_state == S_IDLE);
        update_done = (r_state == S_RESTART);
        timeout     = w_to_hit;
    end

    // Shadow registers and the latched enable only move on accepted writes in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ibrd_sh <= IBRD_RST;
            r_fbrd_sh <= FBRD_RST;
            r_enable  <= 1'b0;
        end else if (w_wr_acc) begin
            case (wr_addr)
                2'd0:    r_ibrd_sh <= wr_data[23:0];
                2'd1:    r_fbrd_sh <= wr_data[7:0];
                2'd2:    r_enable  <= wr_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ibrd       <= IBRD_RST;
            r_fbrd       <= FBRD_RST;
            r_brd_enable <= 1'b0;
            r_brd_rst_n  <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_load_cnt   <= 1'b0;
        end else begin
            r_cfg_err   <= w_bad_commit;
            r_brd_rst_n <= (w_next != S_LOAD);
            r_load_cnt  <= (r_state == S_LOAD) ? ~r_load_cnt : 1'b0;
            if (w_next == S_LOAD && r_state != S_LOAD) begin
                r_ibrd <= r_ibrd_sh;
                r_fbrd <= r_fbrd_sh;
            end
            // Generator is held off through QUIESCE/LOAD; an enable-only CTRL write applies directly.
            if (w_next == S_QUIESCE || w_next == S_LOAD)
                r_brd_enable <= 1'b0;
            else if (w_next == S_RESTART)
                r_brd_enable <= r_enable;
            else if (w_ctrl_wr && !wr_data[1])
                r_brd_enable <= wr_data[0];
        end
    end

    assign ibrd        = r_ibrd;
    assign fbrd        = r_fbrd;
    assign brd_enable  = r_brd_enable;
    assign brd_reset_n = r_brd_rst_n;
    assign cfg_err     = r_cfg_err;

endmodule
